// File: rtl/fpadd_pkg.sv
// Shared constants and state encoding for the fpadd round-robin arbiter.
package fpadd_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/fpadd_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, with wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N-1:0] w_rot;
  logic [IDX_W:0] w_sum;

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    // Bit k of w_rot is the request k positions after the pointer.
    w_rot   = {i_req, i_req} >> i_ptr;
    for (int k = 0; k < N; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
        if (w_sum >= (IDX_W+1)'(N)) begin
          w_sum = w_sum - (IDX_W+1)'(N);
        end
        o_idx = w_sum[IDX_W-1:0];
      end
    end
    if (o_any) begin
      o_grant = {{(N-1){1'b0}}, 1'b1} << o_idx;
    end
  end

endmodule

// File: rtl/fpadd_rr_arbiter.sv
// Shares one multi-cycle fpadd core between NREQ requesters, round-robin,
// with a watchdog that returns qNaN if the core never signals done.
module fpadd_rr_arbiter
  import fpadd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63,
  parameter int IDX_W   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]      rsp_sum,
  output logic                 rsp_timeout,
  output logic                 fpa_start,
  output logic [FP_W-1:0]      fpa_a,
  output logic [FP_W-1:0]      fpa_b,
  input  logic [FP_W-1:0]      fpa_sum,
  input  logic                 fpa_done
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t           r_state,       w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr,      w_rr_ptr_nxt;
  logic [IDX_W-1:0] r_grant,       w_grant_nxt;
  logic [TMR_W-1:0] r_timer,       w_timer_nxt;
  logic [FP_W-1:0]  r_fpa_a,       w_fpa_a_nxt;
  logic [FP_W-1:0]  r_fpa_b,       w_fpa_b_nxt;
  logic [FP_W-1:0]  r_rsp_sum,     w_rsp_sum_nxt;
  logic             r_rsp_timeout, w_rsp_timeout_nxt;

  logic [NREQ-1:0]  w_req_ready;
  logic [NREQ-1:0]  w_rsp_valid;
  logic             w_fpa_start;

  logic [NREQ-1:0]  w_pick_grant;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic [FP_W-1:0]  w_sel_a;
  logic [FP_W-1:0]  w_sel_b;

  rr_pick #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel_a = req_a[i*FP_W +: FP_W];
        w_sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_grant_nxt       = r_grant;
    w_timer_nxt       = r_timer;
    w_fpa_a_nxt       = r_fpa_a;
    w_fpa_b_nxt       = r_fpa_b;
    w_rsp_sum_nxt     = r_rsp_sum;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_req_ready       = '0;
    w_rsp_valid       = '0;
    w_fpa_start       = 1'b0;

    case (r_state)
      IDLE: begin
        w_req_ready = w_pick_grant;
        if (w_pick_any) begin
          w_fpa_a_nxt = w_sel_a;
          w_fpa_b_nxt = w_sel_b;
          w_grant_nxt = w_pick_idx;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_fpa_start = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Timer still zero marks the first WAIT cycle: a done seen here is left
        // over from the previous operation.
        if (r_timer == '0) begin
          w_timer_nxt = TMR_W'(1);
        end else if (fpa_done) begin
          w_rsp_sum_nxt     = fpa_sum;
          w_rsp_timeout_nxt = 1'b0;
          w_state_nxt       = RESP;
        end else if (r_timer == TMR_W'(TIMEOUT)) begin
          w_rsp_sum_nxt     = FP_QNAN;
          w_rsp_timeout_nxt = 1'b1;
          w_state_nxt       = RESP;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      RESP: begin
        w_rsp_valid  = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
        w_rr_ptr_nxt = (r_grant == IDX_W'(NREQ-1)) ? '0 : r_grant + IDX_W'(1);
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_timer       <= '0;
      r_fpa_a       <= '0;
      r_fpa_b       <= '0;
      r_rsp_sum     <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_timer       <= w_timer_nxt;
      r_fpa_a       <= w_fpa_a_nxt;
      r_fpa_b       <= w_fpa_b_nxt;
      r_rsp_sum     <= w_rsp_sum_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  // Ready is combinational in IDLE, so it is masked while reset is held.
  assign req_ready   = w_req_ready & {NREQ{~reset}};
  assign rsp_valid   = w_rsp_valid;
  assign fpa_start   = w_fpa_start;
  assign fpa_a       = r_fpa_a;
  assign fpa_b       = r_fpa_b;
  assign rsp_sum     = r_rsp_sum;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_fpadd_rr_arbiter.sv
// Directed bench for fpadd_rr_arbiter with a behavioural fpadd stub (sum = a ^ b).
module tb_fpadd_rr_arbiter;
  import fpadd_pkg::*;

  localparam int NREQ     = 4;
  localparam int TIMEOUT  = 63;
  localparam int IDX_W    = 2;
  localparam int STUB_LAT = 5;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*32-1:0] req_a    = '0;
  logic [NREQ*32-1:0] req_b    = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_sum;
  logic              rsp_timeout;
  logic              fpa_start;
  logic [31:0]       fpa_a;
  logic [31:0]       fpa_b;
  logic [31:0]       fpa_sum  = '0;
  logic              fpa_done = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  fpadd_rr_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT),
    .IDX_W   (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_sum     (rsp_sum),
    .rsp_timeout (rsp_timeout),
    .fpa_start   (fpa_start),
    .fpa_a       (fpa_a),
    .fpa_b       (fpa_b),
    .fpa_sum     (fpa_sum),
    .fpa_done    (fpa_done)
  );

  always #5 clk = ~clk;

  // fpadd stub. Mode 0: done after STUB_LAT; 1: never done; 2: stale done
  // (with a bogus sum) in the cycle right after start, real done later.
  int          stub_mode = 0;
  int          stub_cnt  = 0;
  logic [31:0] stub_res  = '0;

  always @(posedge clk) begin
    if (fpa_start) begin
      stub_res <= fpa_a ^ fpa_b;
      if (stub_mode == 1) begin
        stub_cnt <= 0;
        fpa_done <= 1'b0;
      end else if (stub_mode == 2) begin
        stub_cnt <= STUB_LAT;
        fpa_done <= 1'b1;
        fpa_sum  <= 32'hDEAD_BEEF;
      end else begin
        stub_cnt <= STUB_LAT;
        fpa_done <= 1'b0;
      end
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        fpa_done <= 1'b1;
        fpa_sum  <= stub_res;
      end else begin
        fpa_done <= 1'b0;
      end
    end
  end

  // Event logger, sampled on the falling edge.
  int          cyc = 0;
  int          acc_idx[$];
  int          acc_cyc[$];
  int          rsp_idx[$];
  int          rsp_cyc[$];
  logic [31:0] rsp_sum_q[$];
  logic        rsp_to_q[$];
  int          start_cyc[$];
  logic [31:0] start_a[$];
  logic [31:0] start_b[$];
  int          ready0_cnt = 0;
  int          bad_oh     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int oh2i(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (|(req_valid & req_ready)) begin
      acc_idx.push_back(oh2i(req_valid & req_ready));
      acc_cyc.push_back(cyc);
    end
    if (req_ready[0]) ready0_cnt++;
    if (fpa_start) begin
      start_cyc.push_back(cyc);
      start_a.push_back(fpa_a);
      start_b.push_back(fpa_b);
    end
    if (|rsp_valid) begin
      rsp_idx.push_back(oh2i(rsp_valid));
      rsp_cyc.push_back(cyc);
      rsp_sum_q.push_back(rsp_sum);
      rsp_to_q.push_back(rsp_timeout);
    end
    if (!$onehot0(rsp_valid) || !$onehot0(req_ready)) bad_oh++;
  end

  task automatic clear_logs();
    acc_idx.delete(); acc_cyc.delete(); rsp_idx.delete(); rsp_cyc.delete();
    rsp_sum_q.delete(); rsp_to_q.delete(); start_cyc.delete();
    start_a.delete(); start_b.delete();
    ready0_cnt = 0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // Requesters drop valid after acceptance unless marked persistent.
  task automatic serve(input logic [NREQ-1:0] persist, input int n_rsp,
                       input int max_cyc, input string name);
    logic [NREQ-1:0] w;
    for (int k = 0; k < max_cyc && rsp_idx.size() < n_rsp; k++) begin
      @(negedge clk);
      w = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(w & ~persist);
    end
    n_chk++;
    if (rsp_idx.size() < n_rsp) begin
      n_fail++;
      $display("FAIL %s wait: got %0d responses, need %0d", name, rsp_idx.size(), n_rsp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] qs(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic qt(input logic q[$], input int i);
    return (i < q.size()) ? q[i] : 1'bx;
  endfunction

  task automatic check_rsp(input string name, input int i, input int idx,
                           input logic [31:0] sum, input logic to);
    n_chk++;
    if (qi(rsp_idx, i) !== idx) begin
      n_fail++;
      $display("FAIL %s rsp%0d idx: got %0d, need %0d", name, i, qi(rsp_idx, i), idx);
    end
    n_chk++;
    if (qs(rsp_sum_q, i) !== sum) begin
      n_fail++;
      $display("FAIL %s rsp%0d sum: got %h, need %h", name, i, qs(rsp_sum_q, i), sum);
    end
    n_chk++;
    if (qt(rsp_to_q, i) !== to) begin
      n_fail++;
      $display("FAIL %s rsp%0d timeout: got %b, need %b", name, i, qt(rsp_to_q, i), to);
    end
  endtask

  task automatic test_reset();
    logic [105:0] outs;
    req_valid = 4'b0001;
    #2;
    outs = {req_ready, rsp_valid, rsp_sum, rsp_timeout, fpa_start, fpa_a, fpa_b};
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h, need 0", outs);
    end
    req_valid = '0;
    #20 reset = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({fpa_start, rsp_valid, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset idle: got %h, need 0", {fpa_start, rsp_valid, req_ready});
    end
  endtask

  task automatic test_round_robin();
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'h100);
    req_valid = 4'hF;
    serve('0, 4, 200, "rr");
    for (int i = 0; i < NREQ; i++) begin
      n_chk++;
      if (qi(acc_idx, i) !== i) begin
        n_fail++;
        $display("FAIL rr accept%0d: got %0d, need %0d", i, qi(acc_idx, i), i);
      end
      check_rsp("rr", i, i, 32'h100 + 32'(i), 1'b0);
      n_chk++;
      if (qi(rsp_cyc, i) - qi(acc_cyc, i) !== 8) begin
        n_fail++;
        $display("FAIL rr latency%0d: got %0d, need 8", i, qi(rsp_cyc, i) - qi(acc_cyc, i));
      end
    end
  endtask

  task automatic test_fairness();
    int exp_idx[6] = '{1, 3, 1, 3, 0, 1};
    clear_logs();
    set_req(0, 32'h7, 32'h100);
    set_req(1, 32'h5, 32'h200);
    set_req(3, 32'h9, 32'h300);
    req_valid = 4'b1010;
    serve(4'b1010, 3, 200, "fair_a");
    req_valid[0] = 1'b1;
    serve(4'b1010, 6, 200, "fair_b");
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (qi(acc_idx, i) !== exp_idx[i]) begin
        n_fail++;
        $display("FAIL fair grant%0d: got %0d, need %0d", i, qi(acc_idx, i), exp_idx[i]);
      end
    end
    check_rsp("fair", 4, 0, 32'h107, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_logs();
    set_req(2, 32'h40, 32'h04);
    req_valid = 4'b0100;
    serve(4'b0100, 2, 200, "b2b");
    req_valid = '0;
    check_rsp("b2b", 0, 2, 32'h44, 1'b0);
    check_rsp("b2b", 1, 2, 32'h44, 1'b0);
    n_chk++;
    if (qi(acc_cyc, 1) - qi(acc_cyc, 0) !== 9) begin
      n_fail++;
      $display("FAIL b2b accept gap: got %0d, need 9", qi(acc_cyc, 1) - qi(acc_cyc, 0));
    end
  endtask

  task automatic test_single_request();
    clear_logs();
    set_req(0, 32'h0000_0000, 32'h4040_0000);
    req_valid = 4'b0001;
    serve('0, 1, 200, "single");
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (ready0_cnt !== 1) begin
      n_fail++;
      $display("FAIL single ready0 cycles: got %0d, need 1", ready0_cnt);
    end
    n_chk++;
    if (start_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL single start pulses: got %0d, need 1", start_cyc.size());
    end
    n_chk++;
    if ({qs(start_a, 0), qs(start_b, 0)} !== {32'h0000_0000, 32'h4040_0000}) begin
      n_fail++;
      $display("FAIL single operands: got %h %h, need 00000000 40400000", qs(start_a, 0), qs(start_b, 0));
    end
    check_rsp("single", 0, 0, 32'h4040_0000, 1'b0);
  endtask

  task automatic test_timeout();
    stub_mode = 1;
    clear_logs();
    set_req(2, 32'h1, 32'h2);
    req_valid = 4'b0100;
    serve('0, 1, 200, "tmo");
    check_rsp("tmo", 0, 2, FP_QNAN, 1'b1);
    n_chk++;
    if (qi(rsp_cyc, 0) - qi(start_cyc, 0) !== TIMEOUT + 2) begin
      n_fail++;
      $display("FAIL tmo latency: got %0d, need %0d", qi(rsp_cyc, 0) - qi(start_cyc, 0), TIMEOUT + 2);
    end
    stub_mode = 0;
    clear_logs();
    set_req(1, 32'h10, 32'h01);
    req_valid = 4'b0010;
    serve('0, 1, 200, "tmo_next");
    check_rsp("tmo_next", 0, 1, 32'h11, 1'b0);
    n_chk++;
    if (qi(rsp_cyc, 0) - qi(acc_cyc, 0) !== 8) begin
      n_fail++;
      $display("FAIL tmo_next latency: got %0d, need 8", qi(rsp_cyc, 0) - qi(acc_cyc, 0));
    end
  endtask

  task automatic test_stale_done();
    stub_mode = 2;
    clear_logs();
    set_req(3, 32'h11, 32'h22);
    req_valid = 4'b1000;
    serve('0, 1, 200, "stale");
    stub_mode = 0;
    check_rsp("stale", 0, 3, 32'h33, 1'b0);
    n_chk++;
    if (qi(rsp_cyc, 0) - qi(acc_cyc, 0) !== 8) begin
      n_fail++;
      $display("FAIL stale latency: got %0d, need 8", qi(rsp_cyc, 0) - qi(acc_cyc, 0));
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [NREQ-1:0] w;
    logic [105:0]    outs;
    clear_logs();
    set_req(2, 32'hA, 32'h5);
    req_valid = 4'b0100;
    for (int k = 0; k < 20 && start_cyc.size() == 0; k++) begin
      @(negedge clk);
      w = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~w;
    end
    n_chk++;
    if (start_cyc.size() == 0) begin
      n_fail++;
      $display("FAIL rst_mid start: got none, need one");
    end
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 32'h0F0, 32'h00F);
    set_req(1, 32'h300, 32'h00C);
    req_valid = 4'b0011;
    #1 reset = 1'b1;
    #1;
    outs = {req_ready, rsp_valid, rsp_sum, rsp_timeout, fpa_start, fpa_a, fpa_b};
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rst_mid outputs: got %h, need 0", outs);
    end
    #1 reset = 1'b0;
    clear_logs();
    serve('0, 2, 200, "rst_mid");
    n_chk++;
    if (qi(acc_idx, 0) !== 0) begin
      n_fail++;
      $display("FAIL rst_mid first grant: got %0d, need 0", qi(acc_idx, 0));
    end
    check_rsp("rst_mid", 0, 0, 32'h0FF, 1'b0);
    check_rsp("rst_mid", 1, 1, 32'h30C, 1'b0);
  endtask

  task automatic test_onehot();
    n_chk++;
    if (bad_oh !== 0) begin
      n_fail++;
      $display("FAIL onehot rsp_valid/req_ready: got %0d bad cycles, need 0", bad_oh);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fairness();
    test_back_to_back();
    test_single_request();
    test_timeout();
    test_stale_done();
    test_reset_mid_wait();
    test_onehot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpadd_rr_arbiter.md
Name: fpadd_rr_arbiter

Overview:
- Shares one multi-cycle fpadd instance between NREQ requesters using round-robin arbitration.
- Per operation: accepts one request, pulses fpa_start with stable operands, waits for fpa_done, captures fpa_sum and returns it to the granted requester as a one-cycle response.
- A watchdog aborts a hung operation.
- Sits between the requesting datapath blocks and the fpadd core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 63, maximum WAIT cycles before abort. Must exceed worst-case fpadd latency (~30 cycles).
- IDX_W, $clog2(NREQ), width of the grant index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot accept; request transfers on valid&ready.
- req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same packing.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse.
- rsp_sum  out  32  result; valid only with rsp_valid.
- rsp_timeout  out  1  qualifies rsp_valid: the operation was aborted.
- fpa_start  out  1  start pulse to fpadd.
- fpa_a  out  32  operand A to fpadd, registered.
- fpa_b  out  32  operand B to fpadd, registered.
- fpa_sum  in  32  fpadd result.
- fpa_done  in  1  fpadd done, level, sticky until next start.

Behaviour:
- Reset (asynchronous, any state) forces:
  - state=IDLE, rr_ptr=0, timer=0.
  - All outputs 0: req_ready, rsp_valid, rsp_sum, rsp_timeout, fpa_start, fpa_a, fpa_b.
  - A reset mid-operation discards the operation; no response is issued. The fpadd's internal state is don't-care, because the next fpa_start reloads it.
- States: IDLE, ISSUE, WAIT, RESP (encoding in package).
- IDLE:
  - req_ready is combinational: one-hot on the first valid requester, searching from rr_ptr upward with wrap-around.
  - On transfer: latch req_a/req_b into fpa_a/fpa_b, latch the grant index, go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - fpa_start=1 for exactly one cycle; fpa_a/fpa_b already stable.
  - Clear timer, go to WAIT.
- WAIT:
  - fpa_done is ignored in the first WAIT cycle (guard against stale done from the previous op).
  - Thereafter, fpa_done=1: capture fpa_sum into rsp_sum, rsp_timeout=0, go to RESP.
  - Otherwise increment timer. At timer==TIMEOUT: rsp_sum=32'h7FC00000 (qNaN), rsp_timeout=1, go to RESP.
  - If fpa_done and the timeout coincide, done wins.
- RESP:
  - rsp_valid[grant]=1 for one cycle.
  - rr_ptr <= grant+1, wrapping to 0 at NREQ.
  - Go to IDLE.
- req_ready is 0 in every state except IDLE. Requesters hold req_valid and operands until accepted.
- fpa_a/fpa_b hold their values until the next accept.
- Latency from accept to rsp_valid: 3 + fpadd latency cycles (ISSUE, guard cycle, done sampling, RESP).
- The minimum gap between accepts is the full operation; there is no pipelining.
- Requester deasserting req_valid before accept: legal, no effect.
- A single persistent requester is served back-to-back. With all NREQ requesting, every requester is served within NREQ operations.

Decomposition:
- Package fpadd_pkg holds:
  - FP_W=32
  - FP_QNAN=32'h7FC00000
  - state encoding constants IDLE/ISSUE/WAIT/RESP
- One combinational sub-module, rr_pick (inputs: req vector, pointer; outputs: one-hot grant, index, any). It is also reusable by other shared-resource arbiters.

Test Plan:
- Single request, integration with the real fpadd: req0 a=32'h00000000, b=32'h40400000 -> req_ready[0] pulses once, fpa_start one cycle, rsp_valid[0]=1 with rsp_sum=32'h40400000, rsp_timeout=0.
- Round-robin, fpadd stub with 5-cycle latency returning a^b: all four requesters valid with req_a=i, req_b=32'h100 -> responses in order 0,1,2,3, sums 32'h100..32'h103, accept-to-response exactly 8 cycles.
- Fairness, same stub: req1 and req3 held continuously -> grants alternate 1,3,1,3. Requester 0 raised mid-stream is granted within 2 operations.
- Timeout, stub never asserting done: -> rsp_valid after ISSUE+TIMEOUT+2 cycles, rsp_sum=32'h7FC00000, rsp_timeout=1. The next request completes normally.
- Stale done, stub holding fpa_done=1 for one cycle after start: -> the guard cycle ignores it, and the result captured is the real done.
- Reset mid-WAIT, asynchronous pulse off the clock edge: -> all outputs 0 immediately, no rsp_valid. The next request goes to requester 0 and completes correctly.
